age_issue_queue: RTL



---
 rtl/age_issue_queue.sv | 79 +++++++
 1 files changed

// File: rtl/age_issue_queue.sv
// age_issue_queue: four-entry age-ordered issue buffer presenting the oldest ready entry
module age_issue_queue #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              enq_rdy_init,
  input  logic              wake_valid,
  input  logic [IDX_W-1:0]  wake_idx,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [DATA_W-1:0] iss_data,
  output logic [IDX_W-1:0]  iss_idx,
  output logic [IDX_W:0]    count
);
  logic [DEPTH-1:0] valid, rdy;
  logic [IDX_W-1:0] age [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic found, fire_iss, fire_enq;
  logic [IDX_W-1:0] sel, sel_age, enq_idx;
  always_comb begin
    found = 1'b0;
    sel = '0;
    sel_age = '0;
    enq_idx = '0;
    count = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && rdy[i] && (!found || age[i] > sel_age)) begin
        found = 1'b1;
        sel = IDX_W'(i);
        sel_age = age[i];
      end
      if (!valid[i]) enq_idx = IDX_W'(i);
      count = count + (IDX_W+1)'(valid[i]);
    end
  end
  assign enq_ready = count < (IDX_W+1)'(DEPTH);
  assign iss_valid = found;
  assign iss_idx = sel;
  assign iss_data = found ? data[sel] : '0;
  assign fire_iss = found & iss_ready;
  assign fire_enq = enq_valid & enq_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      rdy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age[i] <= '0;
        data[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
      rdy <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fire_enq && enq_idx == IDX_W'(i)) begin
          valid[i] <= 1'b1;
          rdy[i] <= enq_rdy_init;
          age[i] <= '0;
          data[i] <= enq_data;
        end else if (fire_iss && sel == IDX_W'(i)) begin
          valid[i] <= 1'b0;
          rdy[i] <= 1'b0;
        end else if (valid[i]) begin
          // entries older than the issued one keep their age across a simultaneous enqueue
          age[i] <= age[i] - IDX_W'(fire_iss && age[i] > sel_age) + IDX_W'(fire_enq);
          if (wake_valid && wake_idx == IDX_W'(i)) rdy[i] <= 1'b1;
        end
      end
    end
  end
endmodule
